// File: rtl/spi_master_if.sv
// Host handshake and SPI bus signals of spi_master.
// The master modport is the controller's view; the slave modport is the host/bus side.
interface spi_master_if #(
  parameter int NSLAVES = 4
);
  localparam int SELW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  logic [7:0]         tx_data;
  logic [SELW-1:0]    tx_sel;
  logic               tx_valid;
  logic               tx_ready;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               busy;
  logic               sck;
  logic               mosi;
  logic               miso;
  logic [NSLAVES-1:0] ss;

  modport master (
    input  tx_data, tx_sel, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, sck, mosi, ss
  );

  modport slave (
    output tx_data, tx_sel, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, sck, mosi, ss
  );
endinterface

// File: rtl/spi_master.sv
// CPOL=0, MSB-first, 8-bit SPI master with one-hot active-high slave selects.
// Every SPI output comes straight from a register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | tx_ready high, waiting for a host byte
// LEAD  | ss asserted, sck low, MSB on mosi; miso captured on last cycle
// HIGH  | sck high, mosi held; last cycle shifts tx or ends the frame
// LOW   | sck low, next bit on mosi; miso captured on last cycle
// TAIL  | sck low after the 8th rising edge, ss still asserted
// GAP   | ss released, enforces minimum deselect time before IDLE
module spi_master #(
  parameter int NSLAVES = 4,
  parameter int HALF    = 4,
  parameter int GAP     = 4
) (
  input  logic         Clk_i,
  input  logic         Rst_i,
  spi_master_if.master bus
);
  localparam int SELW  = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int PMAX  = (HALF > GAP) ? HALF : GAP;
  localparam int PCW   = (PMAX > 2) ? $clog2(PMAX) : 1;
  localparam logic [PCW-1:0] PH_HALF = PCW'(HALF - 1);
  localparam logic [PCW-1:0] PH_GAP  = PCW'(GAP - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_HIGH = 3'd2;
  localparam logic [2:0] S_LOW  = 3'd3;
  localparam logic [2:0] S_TAIL = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [PCW-1:0]     ph_q, ph_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         tx_q, tx_d;
  logic [7:0]         rx_q, rx_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               sck_q, sck_d;
  logic [NSLAVES-1:0] ss_q, ss_d;
  logic [NSLAVES-1:0] ss_dec;
  logic               ph_tc;

  // An out-of-range index decodes to no select at all; the frame still runs.
  always_comb begin
    ss_dec = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (bus.tx_sel == SELW'(i)) ss_dec[i] = 1'b1;
    end
  end

  assign ph_tc = (ph_q == '0);

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sck_d      = sck_q;
    ss_d       = ss_q;
    if (state_q != S_IDLE && !ph_tc) ph_d = ph_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.tx_valid) begin
          state_d = S_LEAD;
          ph_d    = PH_HALF;
          bit_d   = '0;
          tx_d    = bus.tx_data;
          rx_d    = '0;
          ss_d    = ss_dec;
          sck_d   = 1'b0;
        end
      end
      S_LEAD, S_LOW: begin
        if (ph_tc) begin
          state_d = S_HIGH;
          ph_d    = PH_HALF;
          rx_d    = {rx_q[6:0], bus.miso};
          sck_d   = 1'b1;
        end
      end
      S_HIGH: begin
        if (ph_tc) begin
          ph_d  = PH_HALF;
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = S_TAIL;
          end else begin
            state_d = S_LOW;
            bit_d   = bit_q + 1'b1;
            tx_d    = {tx_q[6:0], 1'b0};
          end
        end
      end
      S_TAIL: begin
        if (ph_tc) begin
          state_d    = S_GAP;
          ph_d       = PH_GAP;
          rx_data_d  = (|ss_q) ? rx_q : 8'h00;
          rx_valid_d = 1'b1;
          ss_d       = '0;
          tx_d       = '0;
        end
      end
      S_GAP: begin
        if (ph_tc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      ss_q       <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sck_q      <= sck_d;
      ss_q       <= ss_d;
    end
  end

  // mosi is the tx register MSB, which is cleared when the frame ends.
  assign bus.mosi     = tx_q[7];
  assign bus.sck      = sck_q;
  assign bus.ss       = ss_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
endmodule
